// File: rtl/fpu_fp16_to_int.sv
// FP16 to signed integer converter: two-stage valid/ready pipeline
// (decode, then denormalize / round / saturate / negate).
module fpu_fp16_to_int #(
    parameter int OUTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [15:0]     fpIn,
    input  logic            roundMode,
    output logic            outValid,
    input  logic            outReady,
    output logic [OUTW-1:0] intOut,
    output logic            flagInvalid,
    output logic            flagOverflow,
    output logic            flagInexact
);

    localparam int MW = 32;
    localparam logic [MW-1:0] NEG_LIM = MW'(64'd1 << (OUTW - 1));
    localparam logic [MW-1:0] MAX_POS = NEG_LIM - MW'(1);

    typedef enum logic [2:0] {
        CL_ZERO,
        CL_DENORM,
        CL_NORMAL,
        CL_INF,
        CL_NAN
    } cls_e;

    // Stage 1 (decode) registers
    logic              s1Valid_q;
    logic              s1Sign_q;
    logic              s1Rtz_q;
    cls_e              s1Cls_q;
    logic signed [5:0] s1Exp_q;
    logic [10:0]       s1Sig_q;

    // Stage 2 (convert) registers
    logic              outValid_q;
    logic [OUTW-1:0]   intOut_q;
    logic              flagInv_q;
    logic              flagOvf_q;
    logic              flagInx_q;

    logic              s1Ready;
    logic              s2Ready;

    assign s2Ready  = !outValid_q || outReady;
    assign s1Ready  = !s1Valid_q || s2Ready;
    assign inReady  = rst_n && s1Ready;

    // ---------------- Stage 1 decode ----------------
    logic [4:0]        expF;
    logic [9:0]        fracF;
    cls_e              s1Cls_d;
    logic signed [5:0] s1Exp_d;
    logic [10:0]       s1Sig_d;

    always_comb begin
        expF  = fpIn[14:10];
        fracF = fpIn[9:0];
        if (expF == 5'd0)
            s1Cls_d = (fracF == 10'd0) ? CL_ZERO : CL_DENORM;
        else if (expF == 5'h1F)
            s1Cls_d = (fracF == 10'd0) ? CL_INF : CL_NAN;
        else
            s1Cls_d = CL_NORMAL;
        s1Exp_d = (expF == 5'd0) ? -6'sd14 : ($signed({1'b0, expF}) - 6'sd15);
        s1Sig_d = {expF != 5'd0, fracF};
    end

    // ---------------- Stage 2 convert ----------------
    logic [MW-1:0]   mag;
    logic [MW-1:0]   magR;
    logic [21:0]     shExt;
    logic [5:0]      lsh;
    logic [5:0]      rsh;
    logic            guard;
    logic            sticky;
    logic            rndInc;
    logic [OUTW-1:0] intOut_d;
    logic            flagInv_d;
    logic            flagOvf_d;
    logic            flagInx_d;

    always_comb begin
        mag    = '0;
        shExt  = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        lsh    = 6'(s1Exp_q - 6'sd10);
        rsh    = 6'(6'sd10 - s1Exp_q);
        if (s1Exp_q >= 6'sd10) begin
            mag = {21'b0, s1Sig_q} << lsh;
        end else if (s1Exp_q >= -6'sd1) begin
            // Significand sits on top of 11 zero bits so guard/sticky fall out of the shift.
            shExt  = {s1Sig_q, 11'b0} >> rsh;
            mag    = {21'b0, shExt[21:11]};
            guard  = shExt[10];
            sticky = |shExt[9:0];
        end else begin
            sticky = |s1Sig_q;
        end
        rndInc = !s1Rtz_q && guard && (sticky || mag[0]);
        magR   = mag + MW'(rndInc);

        intOut_d  = '0;
        flagInv_d = 1'b0;
        flagOvf_d = 1'b0;
        flagInx_d = 1'b0;
        case (s1Cls_q)
            CL_NAN: begin
                intOut_d  = MAX_POS[OUTW-1:0];
                flagInv_d = 1'b1;
            end
            CL_INF: begin
                intOut_d  = s1Sign_q ? NEG_LIM[OUTW-1:0] : MAX_POS[OUTW-1:0];
                flagOvf_d = 1'b1;
            end
            CL_ZERO: begin
                intOut_d = '0;
            end
            default: begin
                if (!s1Sign_q && (magR > MAX_POS)) begin
                    intOut_d  = MAX_POS[OUTW-1:0];
                    flagOvf_d = 1'b1;
                end else if (s1Sign_q && (magR > NEG_LIM)) begin
                    intOut_d  = NEG_LIM[OUTW-1:0];
                    flagOvf_d = 1'b1;
                end else begin
                    intOut_d  = s1Sign_q ? (~magR[OUTW-1:0] + OUTW'(1)) : magR[OUTW-1:0];
                    flagInx_d = guard || sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sign_q   <= 1'b0;
            s1Rtz_q    <= 1'b0;
            s1Cls_q    <= CL_ZERO;
            s1Exp_q    <= '0;
            s1Sig_q    <= '0;
            outValid_q <= 1'b0;
            intOut_q   <= '0;
            flagInv_q  <= 1'b0;
            flagOvf_q  <= 1'b0;
            flagInx_q  <= 1'b0;
        end else begin
            if (s1Ready) begin
                s1Valid_q <= inValid;
                if (inValid) begin
                    s1Sign_q <= fpIn[15];
                    s1Rtz_q  <= roundMode;
                    s1Cls_q  <= s1Cls_d;
                    s1Exp_q  <= s1Exp_d;
                    s1Sig_q  <= s1Sig_d;
                end
            end
            if (s2Ready) begin
                outValid_q <= s1Valid_q;
                if (s1Valid_q) begin
                    intOut_q  <= intOut_d;
                    flagInv_q <= flagInv_d;
                    flagOvf_q <= flagOvf_d;
                    flagInx_q <= flagInx_d;
                end
            end
        end
    end

    assign outValid     = outValid_q;
    assign intOut       = intOut_q;
    assign flagInvalid  = flagInv_q;
    assign flagOverflow = flagOvf_q;
    assign flagInexact  = flagInx_q;

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// Directed bench for fpu_fp16_to_int (OUTW=16): rounding, range limits,
// specials, backpressure, throughput and mid-stream reset.
module tb_fpu_fp16_to_int;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [15:0] fpIn;
    logic        roundMode;
    logic        outValid;
    logic        outReady;
    logic [15:0] intOut;
    logic        flagInvalid;
    logic        flagOverflow;
    logic        flagInexact;

    always #5 clk = ~clk;

    fpu_fp16_to_int #(.OUTW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inValid      (inValid),
        .inReady      (inReady),
        .fpIn         (fpIn),
        .roundMode    (roundMode),
        .outValid     (outValid),
        .outReady     (outReady),
        .intOut       (intOut),
        .flagInvalid  (flagInvalid),
        .flagOverflow (flagOverflow),
        .flagInexact  (flagInexact)
    );

    typedef struct {
        string       tag;
        logic [18:0] want;
    } exp_t;

    exp_t        sb[$];
    int          recCyc[$];
    int          cyc = 0;
    int          accCyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // {invalid, overflow, inexact, intOut}
    function automatic logic [18:0] res(input logic [15:0] v, input logic inv, input logic ovf,
                                        input logic inx);
        return {inv, ovf, inx, v};
    endfunction

    // Small positive integer k (< 32) to its exact FP16 encoding.
    function automatic logic [15:0] i2h(input int unsigned k);
        int unsigned p;
        p = 0;
        for (int unsigned i = 0; i < 16; i++) if (((k >> i) & 1) != 0) p = i;
        return {1'b0, 5'(15 + p), 10'((k << (10 - p)) & 32'h3FF)};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && outValid && outReady) begin
            check("output_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, {13'b0, flagInvalid, flagOverflow, flagInexact, intOut}, {13'b0, e.want});
            end
            recCyc.push_back(cyc);
        end
    end

    task automatic send(input logic [15:0] fp, input logic rm, input logic [18:0] want,
                        input string tag);
        exp_t e;
        int   n;
        e.tag  = tag;
        e.want = want;
        sb.push_back(e);
        inValid   = 1'b1;
        fpIn      = fp;
        roundMode = rm;
        n = 0;
        @(negedge clk);
        while (!inReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(inReady), 1);
        accCyc = cyc;
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        int nrec;
        rst_n     = 1'b0;
        inValid   = 1'b0;
        fpIn      = '0;
        roundMode = 1'b0;
        outReady  = 1'b1;
        #2;
        check("reset_state", {11'b0, inReady, outValid, flagInvalid, flagOverflow, flagInexact, intOut}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Rounding and general conversion, fully pipelined
        send(16'h3C00, 1'b0, res(16'h0001, 0, 0, 0), "rne_1p0");
        send(16'h3E00, 1'b0, res(16'h0002, 0, 0, 1), "rne_1p5");
        send(16'h4100, 1'b0, res(16'h0002, 0, 0, 1), "rne_2p5");
        send(16'h4300, 1'b0, res(16'h0004, 0, 0, 1), "rne_3p5");
        send(16'hC100, 1'b0, res(16'hFFFE, 0, 0, 1), "rne_m2p5");
        send(16'h4100, 1'b1, res(16'h0002, 0, 0, 1), "rtz_2p5");
        send(16'h4300, 1'b1, res(16'h0003, 0, 0, 1), "rtz_3p5");
        send(16'h3C01, 1'b0, res(16'h0001, 0, 0, 1), "rne_1p0plus");
        send(16'hC200, 1'b0, res(16'hFFFD, 0, 0, 0), "neg3");
        send(16'h5640, 1'b0, res(16'h0064, 0, 0, 0), "int100");
        send(16'h7400, 1'b0, res(16'h4000, 0, 0, 0), "int16384");
        send(16'hF7FF, 1'b0, res(16'h8010, 0, 0, 0), "neg32752");
        // Small values
        send(16'h3800, 1'b0, res(16'h0000, 0, 0, 1), "rne_0p5");
        send(16'h3A00, 1'b0, res(16'h0001, 0, 0, 1), "rne_0p75");
        send(16'h3A00, 1'b1, res(16'h0000, 0, 0, 1), "rtz_0p75");
        send(16'h0001, 1'b0, res(16'h0000, 0, 0, 1), "denorm_min");
        send(16'h8000, 1'b0, res(16'h0000, 0, 0, 0), "neg_zero");
        // Range limits and specials
        send(16'h7800, 1'b0, res(16'h7FFF, 0, 1, 0), "pos_32768");
        send(16'hF800, 1'b0, res(16'h8000, 0, 0, 0), "neg_32768");
        send(16'h7BFF, 1'b0, res(16'h7FFF, 0, 1, 0), "pos_max_fp");
        send(16'h7C00, 1'b0, res(16'h7FFF, 0, 1, 0), "pos_inf");
        send(16'hFC00, 1'b0, res(16'h8000, 0, 1, 0), "neg_inf");
        send(16'h7E00, 1'b0, res(16'h7FFF, 1, 0, 0), "qnan");
        send(16'hFC01, 1'b0, res(16'h7FFF, 1, 0, 0), "neg_snan");
        drain();

        // Backpressure: consumer stalls while four inputs are offered back to back
        nrec = recCyc.size();
        outReady = 1'b0;
        fork
            begin
                send(16'h4700, 1'b0, res(16'h0007, 0, 0, 0), "bp_7");
                send(16'h4800, 1'b0, res(16'h0008, 0, 0, 0), "bp_8");
                send(16'h4880, 1'b0, res(16'h0009, 0, 0, 0), "bp_9");
                send(16'h4900, 1'b0, res(16'h000A, 0, 0, 0), "bp_10");
            end
            begin
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                check("bp_inready_low", 32'(inReady), 0);
                check("bp_hold0", {12'b0, outValid, flagInvalid, flagOverflow, flagInexact, intOut},
                      {12'b0, 1'b1, 3'b000, 16'h0007});
                @(negedge clk);
                check("bp_hold1", {12'b0, outValid, flagInvalid, flagOverflow, flagInexact, intOut},
                      {12'b0, 1'b1, 3'b000, 16'h0007});
                @(posedge clk);
                #1 outReady = 1'b1;
            end
        join
        drain();
        check("bp_result_count", recCyc.size() - nrec, 4);

        // Throughput: 20 back-to-back inputs, alternating sign
        recCyc.delete();
        acc0 = 0;
        for (int unsigned k = 1; k <= 20; k++) begin
            if ((k % 2) == 0)
                send(i2h(k) | 16'h8000, 1'b0, res(16'(-int'(k)), 0, 0, 0), $sformatf("tp_m%0d", k));
            else
                send(i2h(k), 1'b0, res(16'(k), 0, 0, 0), $sformatf("tp_%0d", k));
            if (k == 1) acc0 = accCyc;
        end
        drain();
        check("tp_count", recCyc.size(), 20);
        if (recCyc.size() == 20) begin
            check("tp_latency", recCyc[0] - acc0, 2);
            check("tp_rate", recCyc[19] - recCyc[0], 19);
        end

        // Reset with both stages full
        outReady = 1'b0;
        send(16'h4700, 1'b0, res(16'h0007, 0, 0, 0), "rst_drop0");
        send(16'h4800, 1'b0, res(16'h0008, 0, 0, 0), "rst_drop1");
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outvalid", 32'(outValid), 0);
        check("rst_inready", 32'(inReady), 0);
        sb.delete();
        recCyc.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        send(16'h4000, 1'b0, res(16'h0002, 0, 0, 0), "post_rst_2p0");
        acc0 = accCyc;
        drain();
        repeat (5) @(negedge clk);
        check("post_rst_count", recCyc.size(), 1);
        if (recCyc.size() == 1) check("post_rst_latency", recCyc[0] - acc0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
